// File: rtl/jump_seq_if.sv
// Interface between the jump sequencer and its neighbours (keyboard decoder
// and physics block). The sequencer takes the slave view; the driving side
// (keyboard/physics or a bench) takes the master view.
interface jump_seq_if #(
  parameter int CW = 6
);
  logic          key_space;
  logic          key_left;
  logic          key_right;
  logic          landed;
  logic          jump_ack;
  logic          jump_req;
  logic [15:0]   jump_vy;
  logic [7:0]    jump_vx;
  logic          walk_left;
  logic          walk_right;
  logic [CW-1:0] charge_level;
  logic [2:0]    state_dbg;

  modport master (
    output key_space, key_left, key_right, landed, jump_ack,
    input  jump_req, jump_vy, jump_vx, walk_left, walk_right, charge_level, state_dbg
  );

  modport slave (
    input  key_space, key_left, key_right, landed, jump_ack,
    output jump_req, jump_vy, jump_vx, walk_left, walk_right, charge_level, state_dbg
  );
endinterface

// File: rtl/jump_seq_ctl.sv
// Player-input jump sequencer: charges jump power while space is held, issues
// one launch request to the physics block on release, waits for landing and
// a cooldown before the next jump, and drives walk commands while idle.
// Optional build macro CHARGE_AUTO_RELEASE_EN: reaching full charge launches
// immediately even with space still held.
//
//   state       | meaning
//   IDLE     0  | grounded, walk commands live, waiting for a space press
//   CHARGE   1  | space held, charge grows once per tick up to MAX_CHARGE
//   LAUNCH   2  | jump_req raised with latched velocities, waiting for ack
//   AIRBORNE 3  | waiting to see the player leave and then touch the ground
//   COOLDOWN 4  | post-landing lockout of COOLDOWN_TICKS ticks, keys ignored
module jump_seq_ctl #(
  parameter int CLOCKS_PER_TICK = 400_000,
  parameter int MAX_CHARGE      = 32,
  parameter int MIN_VEL         = 4,
  parameter int H_SPEED         = 3,
  parameter int COOLDOWN_TICKS  = 8
) (
  input logic     clk,
  input logic     rst,
  jump_seq_if.slave js
);

  localparam int CW  = $clog2(MAX_CHARGE + 1);
  localparam int TW  = (CLOCKS_PER_TICK > 1) ? $clog2(CLOCKS_PER_TICK) : 1;
  localparam int CDW = $clog2(COOLDOWN_TICKS + 1);
  localparam logic [CW-1:0] CHG_MAX = CW'(MAX_CHARGE);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHARGE   = 3'd1,
    ST_LAUNCH   = 3'd2,
    ST_AIRBORNE = 3'd3,
    ST_COOLDOWN = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q;
  logic            space_prev_q;
  logic [CW-1:0]   charge_q, charge_d;
  logic [CDW-1:0]  cool_q, cool_d;
  logic            left_ground_q, left_ground_d;
  logic            req_q, req_d;
  logic [15:0]     vy_q, vy_d;
  logic [7:0]      vx_q, vx_d;
  logic            walk_l_q, walk_l_d;
  logic            walk_r_q, walk_r_d;

  logic            tick;
  logic            space_rise;
  logic            launch_go;
  logic [CW-1:0]   launch_chg;

  assign tick       = (tick_cnt_q == TW'(CLOCKS_PER_TICK - 1));
  assign space_rise = js.key_space & ~space_prev_q;

  // Free-running physics tick base and space edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q   <= '0;
      space_prev_q <= 1'b0;
    end else begin
      tick_cnt_q   <= tick ? '0 : tick_cnt_q + TW'(1);
      space_prev_q <= js.key_space;
    end
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      charge_q      <= '0;
      cool_q        <= '0;
      left_ground_q <= 1'b0;
      req_q         <= 1'b0;
      vy_q          <= '0;
      vx_q          <= '0;
      walk_l_q      <= 1'b0;
      walk_r_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      charge_q      <= charge_d;
      cool_q        <= cool_d;
      left_ground_q <= left_ground_d;
      req_q         <= req_d;
      vy_q          <= vy_d;
      vx_q          <= vx_d;
      walk_l_q      <= walk_l_d;
      walk_r_q      <= walk_r_d;
    end
  end

  // Next-state, charge accumulation, launch latch and walk decode.
  always_comb begin
    state_d       = state_q;
    charge_d      = charge_q;
    cool_d        = cool_q;
    left_ground_d = left_ground_q;
    req_d         = req_q;
    vy_d          = vy_q;
    vx_d          = vx_q;
    walk_l_d      = 1'b0;
    walk_r_d      = 1'b0;
    launch_go     = 1'b0;
    launch_chg    = charge_q;

    case (state_q)
      ST_IDLE: begin
        walk_l_d = js.landed & js.key_left & ~js.key_right;
        walk_r_d = js.landed & js.key_right & ~js.key_left;
        if (space_rise && js.landed) begin
          state_d  = ST_CHARGE;
          charge_d = '0;
        end
      end
      ST_CHARGE: begin
        // Release wins over a tick landing on the same edge.
        if (!js.key_space) begin
          launch_go = 1'b1;
        end else if (tick) begin
          if (charge_q != CHG_MAX) charge_d = charge_q + CW'(1);
`ifdef CHARGE_AUTO_RELEASE_EN
          if (charge_q == CW'(MAX_CHARGE - 1)) begin
            launch_go  = 1'b1;
            launch_chg = CHG_MAX;
          end
`endif
        end
        if (launch_go) begin
          state_d = ST_LAUNCH;
          req_d   = 1'b1;
          vy_d    = 16'd0 - (16'(MIN_VEL) + 16'(launch_chg));
          if (js.key_right && !js.key_left)      vx_d = 8'(H_SPEED);
          else if (js.key_left && !js.key_right) vx_d = 8'd0 - 8'(H_SPEED);
          else                                   vx_d = 8'd0;
        end
      end
      ST_LAUNCH: begin
        if (js.jump_ack && req_q) begin
          state_d       = ST_AIRBORNE;
          req_d         = 1'b0;
          charge_d      = '0;
          left_ground_d = 1'b0;
        end
      end
      ST_AIRBORNE: begin
        if (!js.landed) begin
          left_ground_d = 1'b1;
        end else if (left_ground_q) begin
          state_d       = ST_COOLDOWN;
          left_ground_d = 1'b0;
          cool_d        = '0;
        end
      end
      ST_COOLDOWN: begin
        if (tick) begin
          cool_d = cool_q + CDW'(1);
          if (cool_d == CDW'(COOLDOWN_TICKS)) begin
            state_d = ST_IDLE;
            cool_d  = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign js.jump_req     = req_q;
  assign js.jump_vy      = vy_q;
  assign js.jump_vx      = vx_q;
  assign js.walk_left    = walk_l_q;
  assign js.walk_right   = walk_r_q;
  assign js.charge_level = charge_q;
  assign js.state_dbg    = state_q;

endmodule

// File: tb/tb_jump_seq_ctl.sv
// Directed bench for jump_seq_ctl with a launch scoreboard: stimulus pushes
// the expected launch velocities, a negedge monitor pops them when jump_req
// rises and checks they stay stable while the request is pending.
module tb_jump_seq_ctl;

  localparam int CPT = 4;
  localparam int MAXC = 8;
  localparam int CW = $clog2(MAXC + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jump_seq_if #(.CW(CW)) ifc ();

  jump_seq_ctl #(
    .CLOCKS_PER_TICK(CPT),
    .MAX_CHARGE     (MAXC),
    .MIN_VEL        (4),
    .H_SPEED        (3),
    .COOLDOWN_TICKS (2)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .js (ifc)
  );

  typedef struct packed {
    logic [15:0] vy;
    logic [7:0]  vx;
  } launch_t;

  launch_t sb_q[$];
  launch_t held;
  int checks = 0;
  int failures = 0;
  logic req_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [15:0] vy, input logic [7:0] vx);
    launch_t e;
    e.vy = vy;
    e.vx = vx;
    sb_q.push_back(e);
  endtask

  // Launch monitor.
  always @(negedge clk) begin
    if (ifc.jump_req && !req_prev) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_req: got jump_req=1 with no launch expected");
      end else begin
        held = sb_q.pop_front();
        chk("launch_vy", 32'(ifc.jump_vy), 32'(held.vy));
        chk("launch_vx", 32'(ifc.jump_vx), 32'(held.vx));
      end
    end else if (ifc.jump_req && req_prev) begin
      chk("hold_vy", 32'(ifc.jump_vy), 32'(held.vy));
      chk("hold_vx", 32'(ifc.jump_vx), 32'(held.vx));
    end
    req_prev = ifc.jump_req;
  end

  initial begin
    int n;
    ifc.key_space = 1'b0;
    ifc.key_left  = 1'b0;
    ifc.key_right = 1'b0;
    ifc.landed    = 1'b0;
    ifc.jump_ack  = 1'b0;
    held = '0;
    rst = 1'b1;
    repeat (3) step();
    chk("rst_state", 32'(ifc.state_dbg), 32'd0);
    chk("rst_req",   32'(ifc.jump_req), 32'd0);
    chk("rst_vy",    32'(ifc.jump_vy), 32'd0);
    chk("rst_charge", 32'(ifc.charge_level), 32'd0);
    rst = 1'b0;

    // Walk decode in IDLE.
    ifc.landed = 1'b1; ifc.key_right = 1'b1;
    step();
    chk("walk_r_right", 32'(ifc.walk_right), 32'd1);
    chk("walk_l_right", 32'(ifc.walk_left), 32'd0);
    ifc.key_left = 1'b1;
    step();
    chk("walk_both_r", 32'(ifc.walk_right), 32'd0);
    chk("walk_both_l", 32'(ifc.walk_left), 32'd0);
    ifc.key_right = 1'b0;
    step();
    chk("walk_l_left", 32'(ifc.walk_left), 32'd1);
    ifc.landed = 1'b0;
    step();
    chk("walk_air_l", 32'(ifc.walk_left), 32'd0);
    chk("walk_air_r", 32'(ifc.walk_right), 32'd0);

    // Charge 3 ticks, release right-only: vy=-7, vx=+3.
    ifc.landed = 1'b1; ifc.key_left = 1'b0; ifc.key_right = 1'b1; ifc.key_space = 1'b1;
    step();
    chk("enter_charge", 32'(ifc.state_dbg), 32'd1);
    chk("charge_walk", 32'(ifc.walk_left), 32'd0);
    repeat (12) step();   // any 12 consecutive edges hold exactly 3 ticks
    chk("charge_3", 32'(ifc.charge_level), 32'd3);
    push_exp(16'hFFF9, 8'h03);
    ifc.key_space = 1'b0;
    step();
    chk("launch_state", 32'(ifc.state_dbg), 32'd2);
    chk("launch_req", 32'(ifc.jump_req), 32'd1);

    // Delayed ack; monitor checks stability each cycle.
    repeat (5) step();
    chk("wait_state", 32'(ifc.state_dbg), 32'd2);
    ifc.jump_ack = 1'b1;
    step();
    ifc.jump_ack = 1'b0;
    chk("ack_req", 32'(ifc.jump_req), 32'd0);
    chk("ack_state", 32'(ifc.state_dbg), 32'd3);
    chk("ack_charge", 32'(ifc.charge_level), 32'd0);
    chk("keep_vy", 32'(ifc.jump_vy), 32'h0000FFF9);
    ifc.jump_ack = 1'b1;
    step();
    ifc.jump_ack = 1'b0;
    chk("stray_ack", 32'(ifc.state_dbg), 32'd3);

    // Landing and cooldown.
    ifc.landed = 1'b0;
    step();
    chk("still_air", 32'(ifc.state_dbg), 32'd3);
    ifc.landed = 1'b1;
    step();
    chk("to_cooldown", 32'(ifc.state_dbg), 32'd4);
    ifc.key_space = 1'b1;
    step();
    ifc.key_space = 1'b0;
    step();
    n = 2;
    while (ifc.state_dbg != 3'd0 && n < 20) begin
      step();
      n++;
    end
    chk("cooldown_len_ok", 32'(n >= 5 && n <= 8), 32'd1);
    chk("cooldown_idle", 32'(ifc.state_dbg), 32'd0);
    ifc.landed = 1'b0; ifc.key_space = 1'b1;
    step();
    chk("air_space_ign", 32'(ifc.state_dbg), 32'd0);
    ifc.key_space = 1'b0;
    step();

    // Saturating charge, left-only: vy=-12, vx=-3.
    ifc.landed = 1'b1; ifc.key_left = 1'b1; ifc.key_right = 1'b0; ifc.key_space = 1'b1;
    step();
    chk("charge2_enter", 32'(ifc.state_dbg), 32'd1);
    push_exp(16'hFFF4, 8'hFD);
`ifdef CHARGE_AUTO_RELEASE_EN
    n = 0;
    while (ifc.state_dbg != 3'd2 && n < 40) begin
      step();
      n++;
    end
    chk("auto_launch", 32'(ifc.state_dbg), 32'd2);
    chk("auto_charge", 32'(ifc.charge_level), 32'd8);
`else
    repeat (80) step();
    chk("sat_charge", 32'(ifc.charge_level), 32'd8);
    chk("sat_state", 32'(ifc.state_dbg), 32'd1);
    ifc.key_space = 1'b0;
    step();
    chk("sat_launch", 32'(ifc.state_dbg), 32'd2);
`endif
    chk("sat_req", 32'(ifc.jump_req), 32'd1);

    // Reset during pending launch.
    rst = 1'b1;
    step();
    chk("abort_state", 32'(ifc.state_dbg), 32'd0);
    chk("abort_req", 32'(ifc.jump_req), 32'd0);
    chk("abort_vy", 32'(ifc.jump_vy), 32'd0);
    chk("abort_vx", 32'(ifc.jump_vx), 32'd0);
    chk("abort_walk", 32'({ifc.walk_left, ifc.walk_right}), 32'd0);
    chk("abort_charge", 32'(ifc.charge_level), 32'd0);
    rst = 1'b0;
    step();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
